// File: rtl/blur_seq_pkg.sv
// Shared image-pipeline definitions: sequencer states, priming depth and the
// opaque-black reset pixel.
package blur_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } fsm_state_e;

   localparam int          PRIME_TAPS   = 3;
   localparam logic [31:0] OPAQUE_BLACK = 32'hff000000;

   // Counter width able to hold the value n itself.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/blur_seq_if.sv
// Bundle of control, pixel-stream and datapath signals around the blur sequencer.
// Streams: a beat transfers on a rising edge where valid && ready; valid never waits on ready.
interface blur_seq_if
   import blur_seq_pkg::*;
#(
   parameter int CW = 11,
   parameter int CH = 11
);
   logic          start;
   logic [2:0]    cfg_mode;
   logic [CW-1:0] cfg_width;
   logic [CH-1:0] cfg_height;

   logic          in_valid;
   logic [31:0]   in_data;
   logic          in_ready;

   logic          hb_en;
   logic [2:0]    hb_mode;
   logic [31:0]   hb_data;
   logic [31:0]   hb_blur;

   logic          out_valid;
   logic [31:0]   out_data;
   logic          out_ready;

   logic          busy;
   logic          done;
   fsm_state_e    dbg_state;

   modport slave (
      input  start, cfg_mode, cfg_width, cfg_height,
      input  in_valid, in_data, hb_blur, out_ready,
      output in_ready, hb_en, hb_mode, hb_data,
      output out_valid, out_data, busy, done, dbg_state
   );

   modport master (
      output start, cfg_mode, cfg_width, cfg_height,
      output in_valid, in_data, hb_blur, out_ready,
      input  in_ready, hb_en, hb_mode, hb_data,
      input  out_valid, out_data, busy, done, dbg_state
   );

endinterface

// File: rtl/blur_seq.sv
// Frame sequencer for the horizontal blur datapath: primes the window with each
// row's first pixel, then streams pixels through the datapath with backpressure.
module blur_seq
   import blur_seq_pkg::*;
#(
   parameter int MAXW = 1024,
   parameter int MAXH = 1024
) (
   input  logic      clk,
   input  logic      n_rst,
   blur_seq_if.slave bus
);

   localparam int CW = cnt_width(MAXW);
   localparam int CH = cnt_width(MAXH);

   fsm_state_e    state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [CH-1:0] row_q, row_d;
   logic [1:0]    prime_q, prime_d;
   logic [2:0]    mode_q;
   logic [CW-1:0] width_q;
   logic [CH-1:0] height_q;
   logic          out_valid_q;
   logic [31:0]   out_data_q;

   logic          load_cfg;
   logic          accept;
   logic          in_ready_c;
   logic          hb_en_c;
   logic          done_c;

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      prime_d    = prime_q;
      load_cfg   = 1'b0;
      accept     = 1'b0;
      in_ready_c = 1'b0;
      hb_en_c    = 1'b0;
      done_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               load_cfg = 1'b1;
               col_d    = '0;
               row_d    = '0;
               prime_d  = '0;
               if (bus.cfg_width != '0 && bus.cfg_height != '0) state_d = PRIME;
               else                                             state_d = DONE;
            end
         end
         PRIME: begin
            // The pixel is only peeked here; it is consumed later in RUN.
            if (bus.in_valid) begin
               hb_en_c = 1'b1;
               if (prime_q == 2'(PRIME_TAPS - 1)) begin
                  prime_d = '0;
                  state_d = RUN;
               end else begin
                  prime_d = prime_q + 2'd1;
               end
            end
         end
         RUN: begin
            in_ready_c = !out_valid_q || bus.out_ready;
            accept     = bus.in_valid && in_ready_c;
            if (accept) begin
               hb_en_c = 1'b1;
               if (col_q == width_q - CW'(1)) begin
                  col_d   = '0;
                  row_d   = row_q + CH'(1);
                  state_d = (row_q == height_q - CH'(1)) ? DONE : PRIME;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         DONE: begin
            if (!out_valid_q) begin
               done_c  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         prime_q     <= '0;
         mode_q      <= '0;
         width_q     <= '0;
         height_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= OPAQUE_BLACK;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         prime_q <= prime_d;
         if (load_cfg) begin
            mode_q   <= bus.cfg_mode;
            width_q  <= bus.cfg_width;
            height_q <= bus.cfg_height;
         end
         // Output register only changes on accept, so data holds during stalls.
         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.hb_blur;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.hb_en     = hb_en_c;
   assign bus.hb_data   = bus.in_data;
   assign bus.hb_mode   = (state_q == IDLE) ? 3'b000 : mode_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = (state_q != IDLE) && !done_c;
   assign bus.done      = done_c;
   assign bus.dbg_state = state_q;

endmodule

// File: doc/blur_seq.md
BLUR_SEQ -- requirements
Module: blur_seq

Interface
REQ-001 Parameter MAXW, default 1024, max row width in pixels; counter widths = $clog2(MAXW)+1.
REQ-002 Parameter MAXH, default 1024, max frame height in rows.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 n_rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 start  input  1  single-cycle frame start request.
REQ-006 cfg_mode  input  3  blur mode, latched on accepted start.
REQ-007 cfg_width / cfg_height  input  CW / CH  frame dimensions, latched on accepted start.
REQ-008 in_valid, in_data[31:0] input; in_ready output: source pixel stream (ARGB, alpha MSB).
REQ-009 hb_en  output  1  window-shift enable to horizontal blur datapath (its wb_en).
REQ-010 hb_mode  output  3  mode to datapath (its mode_wb); hb_data output 32 pixel to datapath.
REQ-011 hb_blur  input  32  combinational blurred result from datapath.
REQ-012 out_valid, out_data[31:0] output; out_ready input: blurred pixel stream.
REQ-013 busy output 1 high from accepted start to done; done output 1 single-cycle frame-complete pulse.

Function
REQ-014 States SHALL be IDLE, PRIME, RUN, DONE.
REQ-015 IDLE: start with cfg_width!=0 and cfg_height!=0 latches cfg, clears col/row/prime counters, -> PRIME next cycle; start with a zero dimension -> DONE directly (done pulse, no pixels).
REQ-016 start while busy SHALL be ignored; cfg changes while busy SHALL have no effect.
REQ-017 PRIME (edge replication): in_ready=0, hb_data=in_data; each cycle in_valid=1, hb_en=1 and prime counter increments; after 3 pulses -> RUN; in_valid=0 holds state, no hb_en.
REQ-018 RUN: in_ready = !out_valid || out_ready; hb_data=in_data; accept = in_valid && in_ready.
REQ-019 On accept: hb_en=1 same cycle, out_data<=hb_blur, out_valid<=1, col increments.
REQ-020 out_valid SHALL clear on out_ready with no new accept in that cycle; out_data SHALL be held stable while out_valid && !out_ready.
REQ-021 hb_en SHALL be high only in REQ-017/REQ-019 cycles; never two pulses per pixel in RUN.
REQ-022 Accept at col==width-1: col<=0, row increments; if row!=height-1 -> PRIME (re-prime next row's first pixel), else -> DONE.
REQ-023 DONE: waits until out_valid==0 (last pixel drained), then done=1 one cycle, busy=0, -> IDLE.
REQ-024 Latency: pixel accepted in cycle N appears on out_data/out_valid in N+1; full throughput 1 pixel/cycle in RUN with out_ready=1; PRIME costs 3 in_valid cycles per row.
REQ-025 Result for column c SHALL equal datapath average of pixels c-3..c, indices <0 replaced by pixel 0 of that row.
REQ-026 hb_mode = latched mode while busy, 3'b000 in IDLE.

Reset
REQ-027 On n_rst=0: state IDLE, counters 0, out_valid=0, out_data=32'hff000000, hb_en=0, in_ready=0, busy=0, done=0, latched mode/width/height 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no done pulse; datapath resets via the same n_rst.

Structure
REQ-029 State enum (IDLE/PRIME/RUN/DONE), PRIME_TAPS=3 and OPAQUE_BLACK=32'hff000000 SHALL live in the shared image-pipeline package.
REQ-030 blur_seq SHALL NOT instantiate horblur; a wrapper blur_stage instantiates blur_seq plus horblur; no other sub-module.

Verification
REQ-031 Reset: n_rst low mid-RUN -> out_data=32'hff000000, out_valid=0, busy=0, no done pulse.
REQ-032 Width 4, height 1, mode 3'b101, pixels all 32'hffffffff, out_ready=1 -> 3 PRIME hb_en pulses, 4 outputs each 32'hffffffff, done 1 cycle after last output.
REQ-033 Width 4, height 1, pixels 0x00000000,0x00040404,0x00080808,0x000c0c0c -> outputs carry average per REQ-025 (col3 = (0+4+8+12)/4 = 6 per channel).
REQ-034 Backpressure: out_ready low 5 cycles mid-row -> in_ready=0, hb_en=0, out_data stable; resume with no pixel lost or duplicated.
REQ-035 Width 2, height 3 -> PRIME entered 3 times (9 prime pulses total), 6 outputs, single done.
REQ-036 start with cfg_height=0 -> done pulse next cycle, no hb_en, no out_valid; start during busy ignored.
